fpu_result_capture: RTL and testbench
=====================================

Name: fpu_result_capture

Overview:
Sink end of the FPU test path. It captures each result word, op code and exception flags from the arithmetic unit through a valid/ready handshake. Results go into a NUM_VECTORS-deep result memory indexed in the same order the operand source issues operand pairs. A registered read port lets the display/UART logic or the bench read entries back. It signals when a full vector set has been captured.

Parameters:
WIDTH, 32, result word width (IEEE-754 single).
NUM_VECTORS, 12, entries per vector set; index wraps after NUM_VECTORS-1.
AW, 4, address/index width; must satisfy 2^AW >= NUM_VECTORS.
WRAP_MODE, 1, 1 = keep capturing and wrap index to 0; 0 = stop when full.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous soft clear of index/count/status
res_valid  in  1  ALU result valid
res_ready  out  1  capture can accept a result this cycle
result  in  WIDTH  result word
op_sel  in  2  operation code (00 add, 01 sub, 10 mul, 11 div)
flags  in  5  {invalid, divzero, overflow, underflow, inexact}
rd_en  in  1  read request
rd_addr  in  AW  read index
rd_data  out  WIDTH  read result word
rd_op  out  2  read op code
rd_flags  out  5  read flags
rd_valid  out  1  one-cycle pulse: rd_* outputs valid
wr_index  out  AW  next entry to be written
count  out  AW+1  entries captured since reset/clear, saturates at NUM_VECTORS
done  out  1  one-cycle pulse when entry NUM_VECTORS-1 is written
full  out  1  WRAP_MODE=0 only: all entries written, capture halted
overrun  out  1  sticky: res_valid seen while halted

Behaviour:
- Reset (rst_n low, asynchronous): state CAPTURE; wr_index 0; count 0; done, full, overrun, rd_valid 0; rd_data/rd_op/rd_flags 0; all per-entry written bits cleared. Memory array contents are not reset.
- States:
  - CAPTURE: res_ready = 1.
  - HALT: res_ready = 0, full = 1. Reachable only with WRAP_MODE=0.
- res_ready is decoded combinationally from state and clear. It is 0 in any cycle where clear = 1.
- Accept occurs when res_valid && res_ready. On that edge:
  - {result, op_sel, flags} is written to entry wr_index and its written bit is set.
  - count increments, saturating at NUM_VECTORS.
- Index advance on accept:
  - wr_index < NUM_VECTORS-1: wr_index + 1.
  - wr_index == NUM_VECTORS-1: done pulses high for the next cycle.
    - WRAP_MODE=1: wr_index goes to 0 and state stays CAPTURE.
    - WRAP_MODE=0: wr_index holds at NUM_VECTORS-1 and state goes to HALT.
- HALT: res_valid = 1 sets overrun (sticky). No write occurs.
- clear = 1 (synchronous):
  - wr_index, count, full, overrun and all written bits go to 0; state goes to CAPTURE; done is 0.
  - Memory data is untouched.
  - clear has priority over a same-cycle accept; that result is dropped.
- Read port, 1-cycle latency: rd_en sampled at edge N gives rd_data/rd_op/rd_flags and rd_valid = 1 after edge N.
  - rd_valid is 0 in cycles without a registered read. rd_* data outputs hold their last value otherwise.
  - rd_addr >= NUM_VECTORS, or entry not written: data outputs return 0 and rd_valid is still 1.
  - Read and accept to the same entry in the same cycle: read returns the pre-write contents. A written bit set by this accept does not affect this read.
- Reset asserted mid-operation aborts everything immediately. After release: CAPTURE, res_ready = 1.

Test Plan:
- Reset release, then 3 accepts: 32'h40400000/op 00/flags 0, 32'hC6179C6F/op 00, 32'h7FC00000/op 00/flags 5'b10000 -> wr_index 3, count 3; rd_addr 2 gives rd_data 7FC00000, rd_flags 10000, rd_valid 1 cycle after rd_en.
- WRAP_MODE=1, 13 back-to-back accepts with values 1..13 -> done pulses one cycle after the 12th accept; wr_index 1; count 12; entry 0 reads 13, entry 1 reads 2.
- WRAP_MODE=0, 12 accepts, then res_valid held 2 cycles -> full 1, res_ready 0, overrun 1, entry 11 unchanged; clear -> full 0, overrun 0, res_ready 1, wr_index 0.
- Read entry 5 before any write, and rd_addr 14 -> rd_data 0, rd_flags 0, rd_valid 1; same-cycle write 32'h3F800000 and read of entry 0 after a prior 32'h40000000 write there -> read returns 40000000.
- clear and res_valid in the same cycle with count 4 -> count 0, no entry written; rst_n pulsed low mid-sequence asynchronously -> all status outputs 0 before the next clk edge.

Source files
------------

// File: rtl/fpu_result_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_result_capture                                                         |
// | Captures FPU results into an indexed result memory with a registered read  |
// | port, vector-set completion pulse, and optional halt-on-full behaviour.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_result_capture #(
  parameter int WIDTH       = 32,
  parameter int NUM_VECTORS = 12,
  parameter int AW          = 4,
  parameter int WRAP_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] result,
  input  logic [1:0]       op_sel,
  input  logic [4:0]       flags,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       rd_op,
  output logic [4:0]       rd_flags,
  output logic             rd_valid,
  output logic [AW-1:0]    wr_index,
  output logic [AW:0]      count,
  output logic             done,
  output logic             full,
  output logic             overrun
);

  localparam int            c_ent_w    = WIDTH + 7;
  localparam logic [AW-1:0] c_last_idx = AW'(NUM_VECTORS - 1);
  localparam logic [AW:0]   c_num_vec  = (AW + 1)'(NUM_VECTORS);

  typedef enum logic [0:0] {
    ST_CAPTURE = 1'b0,
    ST_HALT    = 1'b1
  } state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_wr_index;
  logic [AW:0]              r_count;
  logic                     r_done;
  logic                     r_full;
  logic                     r_overrun;
  logic [NUM_VECTORS-1:0]   r_written;
  logic [c_ent_w-1:0]       r_mem [NUM_VECTORS];
  logic [WIDTH-1:0]         r_rd_data;
  logic [1:0]               r_rd_op;
  logic [4:0]               r_rd_flags;
  logic                     r_rd_valid;

  logic                     w_accept;
  logic                     w_at_last;
  logic                     w_rd_hit;
  logic [c_ent_w-1:0]       w_rd_entry;

  assign res_ready = (r_state == ST_CAPTURE) && !clear;
  assign w_accept  = res_valid && res_ready;
  assign w_at_last = (r_wr_index == c_last_idx);

  // Out-of-range or never-written entries read back as zero.
  always_comb begin
    w_rd_hit   = 1'b0;
    w_rd_entry = '0;
    if (rd_addr <= c_last_idx) begin
      w_rd_hit   = r_written[rd_addr];
      w_rd_entry = r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_index] <= {result, op_sel, flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CAPTURE;
      r_wr_index <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_full     <= 1'b0;
      r_overrun  <= 1'b0;
      r_written  <= '0;
      r_rd_data  <= '0;
      r_rd_op    <= '0;
      r_rd_flags <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (w_rd_hit) begin
          {r_rd_data, r_rd_op, r_rd_flags} <= w_rd_entry;
        end else begin
          {r_rd_data, r_rd_op, r_rd_flags} <= '0;
        end
      end

      if (clear) begin
        r_state    <= ST_CAPTURE;
        r_wr_index <= '0;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_full     <= 1'b0;
        r_overrun  <= 1'b0;
        r_written  <= '0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          ST_CAPTURE: begin
            if (w_accept) begin
              r_written[r_wr_index] <= 1'b1;
              if (r_count != c_num_vec) begin
                r_count <= r_count + 1'b1;
              end
              if (w_at_last) begin
                r_done <= 1'b1;
                if (WRAP_MODE != 0) begin
                  r_wr_index <= '0;
                end else begin
                  r_state <= ST_HALT;
                  r_full  <= 1'b1;
                end
              end else begin
                r_wr_index <= r_wr_index + 1'b1;
              end
            end
          end
          ST_HALT: begin
            if (res_valid) begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= ST_CAPTURE;
        endcase
      end
    end
  end

  assign wr_index = r_wr_index;
  assign count    = r_count;
  assign done     = r_done;
  assign full     = r_full;
  assign overrun  = r_overrun;
  assign rd_data  = r_rd_data;
  assign rd_op    = r_rd_op;
  assign rd_flags = r_rd_flags;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_result_capture                                                      |
// | Wrapping and halting instances share stimulus; reads go through a queue.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fpu_result_capture;

  localparam int NV = 12;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  op;
    logic [4:0]  fl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] result = '0;
  logic [1:0]  op_sel = '0;
  logic [4:0]  flags = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        w_rdy, h_rdy, w_rdv, h_rdv, w_done, h_done, w_full, h_full, w_ovr, h_ovr;
  logic [31:0] w_rdd, h_rdd;
  logic [1:0]  w_rdo, h_rdo;
  logic [4:0]  w_rdf, h_rdf;
  logic [3:0]  w_idx, h_idx;
  logic [4:0]  w_cnt, h_cnt;

  fpu_result_capture #(.WIDTH(32), .NUM_VECTORS(NV), .AW(4), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .res_valid(res_valid), .res_ready(w_rdy),
    .result(result), .op_sel(op_sel), .flags(flags), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(w_rdd), .rd_op(w_rdo), .rd_flags(w_rdf), .rd_valid(w_rdv),
    .wr_index(w_idx), .count(w_cnt), .done(w_done), .full(w_full), .overrun(w_ovr)
  );

  fpu_result_capture #(.WIDTH(32), .NUM_VECTORS(NV), .AW(4), .WRAP_MODE(0)) u_halt (
    .clk(clk), .rst_n(rst_n), .clear(clear), .res_valid(res_valid), .res_ready(h_rdy),
    .result(result), .op_sel(op_sel), .flags(flags), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(h_rdd), .rd_op(h_rdo), .rd_flags(h_rdf), .rd_valid(h_rdv),
    .wr_index(h_idx), .count(h_cnt), .done(h_done), .full(h_full), .overrun(h_ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: index 0 = wrapping instance, 1 = halting instance.
  // Position is derived from the number of accepts since reset/clear.
  int   m_acc [2];
  bit   m_done[2];
  bit   m_ovr [2];
  bit   m_wr  [2][NV];
  ent_t m_mem [2][NV];
  ent_t q_w[$];
  ent_t q_h[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit halted(input int m);
    return (m == 1) && (m_acc[m] >= NV);
  endfunction

  function automatic int idx_of(input int m);
    if (m == 0) return m_acc[m] % NV;
    return (m_acc[m] >= NV) ? NV - 1 : m_acc[m];
  endfunction

  function automatic int cnt_of(input int m);
    return (m_acc[m] >= NV) ? NV : m_acc[m];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0; m_done[m] = 0; m_ovr[m] = 0;
      for (int i = 0; i < NV; i++) m_wr[m][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      ent_t e;
      bit   h;
      int   i;
      e = '0;
      if (rd_en) begin
        if (rd_addr < NV) begin
          if (m_wr[m][rd_addr]) e = m_mem[m][rd_addr];
        end
        if (m == 0) q_w.push_back(e); else q_h.push_back(e);
      end
      h = halted(m);
      m_done[m] = 0;
      if (clear) begin
        m_acc[m] = 0;
        m_ovr[m] = 0;
        for (int k = 0; k < NV; k++) m_wr[m][k] = 0;
      end else if (h) begin
        if (res_valid) m_ovr[m] = 1;
      end else if (res_valid) begin
        i = idx_of(m);
        m_mem[m][i] = {result, op_sel, flags};
        m_wr[m][i]  = 1;
        m_acc[m]++;
        m_done[m] = (m_acc[m] % NV) == 0;
      end
    end
  endtask

  task automatic chk_status();
    chk("w.res_ready", w_rdy, !halted(0) && !clear);
    chk("w.wr_index",  w_idx, idx_of(0));
    chk("w.count",     w_cnt, cnt_of(0));
    chk("w.done",      w_done, m_done[0]);
    chk("w.full",      w_full, halted(0));
    chk("w.overrun",   w_ovr, m_ovr[0]);
    chk("h.res_ready", h_rdy, !halted(1) && !clear);
    chk("h.wr_index",  h_idx, idx_of(1));
    chk("h.count",     h_cnt, cnt_of(1));
    chk("h.done",      h_done, m_done[1]);
    chk("h.full",      h_full, halted(1));
    chk("h.overrun",   h_ovr, m_ovr[1]);
  endtask

  task automatic chk_reset_outputs();
    chk_status();
    chk("w.rd_valid_rst", w_rdv, 0);
    chk("w.rd_word_rst",  {w_rdd, w_rdo, w_rdf}, 0);
    chk("h.rd_valid_rst", h_rdv, 0);
    chk("h.rd_word_rst",  {h_rdd, h_rdo, h_rdf}, 0);
  endtask

  task automatic cyc(input bit v, input logic [31:0] r, input logic [1:0] o, input logic [4:0] f,
                     input bit re, input logic [3:0] ra, input bit cl);
    res_valid = v; result = r; op_sel = o; flags = f;
    rd_en = re; rd_addr = ra; clear = cl;
    model_step();
    @(posedge clk);
    #2;
    chk_status();
  endtask

  task automatic idle();
    cyc(0, 32'h0, 2'b00, 5'b0, 0, 4'd0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(0, 32'h0, 2'b00, 5'b0, 1, a, 0);
  endtask

  task automatic mon_one(input string tag, input bit m, input logic v, input ent_t act);
    ent_t e;
    if (v) begin
      if ((m ? q_h.size() : q_w.size()) == 0) begin
        chk({tag, ".rd_valid_unexpected"}, v, 0);
      end else begin
        e = m ? q_h.pop_front() : q_w.pop_front();
        chk({tag, ".rd_word"}, act, e);
      end
    end else if ((m ? q_h.size() : q_w.size()) != 0) begin
      chk({tag, ".rd_valid_missing"}, v, 1);
      if (m) q_h.delete(); else q_w.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      mon_one("w", 0, w_rdv, {w_rdd, w_rdo, w_rdf});
      mon_one("h", 1, h_rdv, {h_rdd, h_rdo, h_rdf});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs();
    rst_n = 1'b1;
    #1;

    // Basic capture and readback.
    cyc(1, 32'h40400000, 2'b00, 5'b00000, 0, 4'd0, 0);
    cyc(1, 32'hC6179C6F, 2'b00, 5'b00000, 0, 4'd0, 0);
    cyc(1, 32'h7FC00000, 2'b00, 5'b10000, 0, 4'd0, 0);
    rd(4'd2);
    idle();

    // Full vector set plus one: wrap vs halt, then overrun.
    cyc(0, 32'h0, 2'b00, 5'b0, 0, 4'd0, 1);
    for (int i = 1; i <= 13; i++) cyc(1, i, 2'(i), 5'(i), 0, 4'd0, 0);
    rd(4'd0); rd(4'd1); rd(4'd11);
    cyc(1, 32'hDEADBEEF, 2'b11, 5'b11111, 0, 4'd0, 0);
    cyc(1, 32'hDEADBEEF, 2'b11, 5'b11111, 0, 4'd0, 0);
    rd(4'd11);
    cyc(0, 32'h0, 2'b00, 5'b0, 0, 4'd0, 1);
    idle();

    // Unwritten and out-of-range reads, then read-during-write on entry 0.
    rd(4'd5); rd(4'd14); rd(4'd15);
    cyc(1, 32'h40000000, 2'b10, 5'b00001, 0, 4'd0, 0);
    for (int i = 1; i < NV; i++) cyc(1, 32'h1000 + i, 2'b01, 5'b0, 0, 4'd0, 0);
    cyc(1, 32'h3F800000, 2'b10, 5'b00000, 1, 4'd0, 0);
    rd(4'd0);
    idle();

    // Clear beats a same-cycle accept.
    cyc(0, 32'h0, 2'b00, 5'b0, 0, 4'd0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 32'hA0 + i, 2'b00, 5'b0, 0, 4'd0, 0);
    cyc(1, 32'hBADBAD00, 2'b11, 5'b00100, 0, 4'd0, 1);
    rd(4'd0); rd(4'd4);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0, $urandom, 2'($urandom), 5'($urandom),
          ($urandom % 2) != 0, 4'($urandom), ($urandom % 40) == 0);
    end

    // Asynchronous reset between edges.
    cyc(1, 32'h12345678, 2'b01, 5'b00010, 0, 4'd0, 0);
    cyc(1, 32'h87654321, 2'b10, 5'b00100, 1, 4'd0, 0);
    #1;
    res_valid = 0; rd_en = 0; clear = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk);
    #2;
    chk_reset_outputs();
    rst_n = 1'b1;
    #1;
    rd(4'd0);
    for (int n = 0; n < 60; n++) begin
      cyc(($urandom % 3) != 0, $urandom, 2'($urandom), 5'($urandom),
          ($urandom % 2) != 0, 4'($urandom), ($urandom % 50) == 0);
    end
    idle();
    idle();
    chk("w.queue_drained", q_w.size(), 0);
    chk("h.queue_drained", q_h.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
